// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 active-low key matrix one column at a time,
// debounces the first key found and reports it as code/keydown/key_strobe.
// Ports: clk, rst (sync, active-high); row (async, active-low, pulled up);
//        col (one-hot active-low drive); code/keydown/key_strobe (key report);
//        scan_clk (one-cycle pulse at every row sample point).
module keypad_matrix_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       keydown,
  output logic       key_strobe,
  output logic       scan_clk
);
  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_LAST   = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    row_m, row_s;
  logic [DW-1:0] dwell;
  logic          sample;
  logic [3:0]    col_nxt, col_rot;
  logic [1:0]    cur_col, low_row;
  logic [1:0]    row_idx, row_idx_nxt;
  logic [1:0]    key_col, key_col_nxt;
  logic [3:0]    deb_cnt, deb_nxt, deb_inc;
  logic [3:0]    rel_cnt, rel_nxt, rel_inc;
  logic [3:0]    code_nxt;
  logic          keydown_nxt, strobe_nxt;
  logic          tracked_hi;

  assign sample     = (dwell == DWELL_LAST);
  assign scan_clk   = sample;
  assign col_rot    = {col[2:0], col[3]};
  assign deb_inc    = deb_cnt + 4'd1;
  assign rel_inc    = rel_cnt + 4'd1;
  // Only the row latched at detection is watched; other keys in the column are ignored.
  assign tracked_hi = row_s[row_idx];

  always_comb begin
    case (col)
      4'b1101: cur_col = 2'd1;
      4'b1011: cur_col = 2'd2;
      4'b0111: cur_col = 2'd3;
      default: cur_col = 2'd0;
    endcase
  end

  // Lowest active row wins when several keys share the column.
  always_comb begin
    if      (!row_s[0]) low_row = 2'd0;
    else if (!row_s[1]) low_row = 2'd1;
    else if (!row_s[2]) low_row = 2'd2;
    else                low_row = 2'd3;
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    row_idx_nxt = row_idx;
    key_col_nxt = key_col;
    deb_nxt     = deb_cnt;
    rel_nxt     = rel_cnt;
    code_nxt    = code;
    keydown_nxt = keydown;
    strobe_nxt  = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (row_s == 4'b1111) begin
            col_nxt = col_rot;
          end else begin
            row_idx_nxt = low_row;
            key_col_nxt = cur_col;
            if (DEBOUNCE_N == 1) begin
              code_nxt    = {low_row, cur_col};
              keydown_nxt = 1'b1;
              strobe_nxt  = 1'b1;
              rel_nxt     = 4'd0;
              deb_nxt     = 4'd0;
              state_nxt   = PRESSED;
            end else begin
              deb_nxt   = 4'd1;
              state_nxt = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!tracked_hi) begin
            if (deb_inc == DEB_LAST) begin
              code_nxt    = {row_idx, key_col};
              keydown_nxt = 1'b1;
              strobe_nxt  = 1'b1;
              rel_nxt     = 4'd0;
              deb_nxt     = 4'd0;
              state_nxt   = PRESSED;
            end else begin
              deb_nxt = deb_inc;
            end
          end else begin
            // Bounce: give up silently and move on to the next column.
            deb_nxt   = 4'd0;
            col_nxt   = col_rot;
            state_nxt = SCAN;
          end
        end
        PRESSED: begin
          if (tracked_hi) begin
            if (rel_inc == DEB_LAST) begin
              keydown_nxt = 1'b0;
              rel_nxt     = 4'd0;
              col_nxt     = col_rot;
              state_nxt   = SCAN;
            end else begin
              rel_nxt = rel_inc;
            end
          end else begin
            rel_nxt = 4'd0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_m      <= 4'b1111;
      row_s      <= 4'b1111;
      dwell      <= '0;
      state      <= SCAN;
      col        <= 4'b1110;
      row_idx    <= 2'd0;
      key_col    <= 2'd0;
      deb_cnt    <= 4'd0;
      rel_cnt    <= 4'd0;
      code       <= 4'd0;
      keydown    <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      row_m      <= row;
      row_s      <= row_m;
      // Restart on any column change so every column gets a full settle time.
      dwell      <= (sample || (col_nxt != col)) ? '0 : dwell + DW'(1);
      state      <= state_nxt;
      col        <= col_nxt;
      row_idx    <= row_idx_nxt;
      key_col    <= key_col_nxt;
      deb_cnt    <= deb_nxt;
      rel_cnt    <= rel_nxt;
      code       <= code_nxt;
      keydown    <= keydown_nxt;
      key_strobe <= strobe_nxt;
    end
  end
endmodule
